// File: rtl/da_pkg.sv
// Shared widths, tap count, pair-slot derivation and FSM state encoding for the
// distributed-arithmetic operand generator.
package da_pkg;

    localparam int DA_DATA_WIDTH_A = 16;
    localparam int DA_DATA_WIDTH_B = 16;
    localparam int DA_K            = 9;

    // Tap 0 gets its own slot; the remaining taps are folded in pairs.
    function automatic int da_pair_slots(input int k);
        return (k + 1) / 2;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } da_state_e;

endpackage

// File: rtl/da_bit_transpose.sv
// Combinational transpose of N words of W bits into W bit-slices of N bits:
// slice s, bit j is bit s of word j.
module da_bit_transpose #(
    parameter int W = 16,
    parameter int N = 9
) (
    input  logic [N-1:0][W-1:0] words_i,
    output logic [W-1:0][N-1:0] slices_o
);

    for (genvar s = 0; s < W; s++) begin : g_slice
        for (genvar j = 0; j < N; j++) begin : g_word
            assign slices_o[s][j] = words_i[j][s];
        end
    end

endmodule

// File: rtl/da_operand_gen.sv
// Operand generator for a distributed-arithmetic dot product: captures one A/B set,
// builds bit-sliced LUT addresses and pair sums/differences, then steps slices LSB-first.
module da_operand_gen
    import da_pkg::*;
#(
    parameter int DATA_WIDTH_A = DA_DATA_WIDTH_A,
    parameter int DATA_WIDTH_B = DA_DATA_WIDTH_B,
    parameter int K            = DA_K,
    parameter int sK           = da_pair_slots(K)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [K-1:0][DATA_WIDTH_A-1:0]        A,
    input  logic [K-1:0][DATA_WIDTH_B-1:0]        B,
    input  logic                                  hold,
    output logic [DATA_WIDTH_A-1:0][K-1:0]        addr_array,
    output logic signed [sK-1:0][DATA_WIDTH_B:0]  B_A_array,
    output logic signed [sK-1:0][DATA_WIDTH_B:0]  B_M_array,
    output logic [7:0]                            t,
    output logic [DATA_WIDTH_A-1:0]               A0,
    output logic                                  gen_done,
    output logic                                  done
);

    localparam int BW  = DATA_WIDTH_B + 1;
    localparam int PAD = 2 * sK - 1;
    localparam int NB  = (K < PAD) ? K : PAD;
    localparam logic [7:0]              T_LAST  = 8'(DATA_WIDTH_A - 1);
    localparam logic [DATA_WIDTH_A-1:0] A0_MARK = DATA_WIDTH_A'(1) << (DATA_WIDTH_A - 1);

    da_state_e                        state_q, state_d;
    logic [7:0]                       t_q, t_d;
    logic [K-1:0][DATA_WIDTH_A-1:0]   a_q;
    logic [K-1:0][DATA_WIDTH_B-1:0]   b_q;
    logic [DATA_WIDTH_A-1:0][K-1:0]   addr_q, addr_d;
    logic [sK-1:0][BW-1:0]            ba_q, ba_d, bm_q, bm_d;
    logic [PAD-1:0][BW-1:0]           b_ext;
    logic                             accept;

    assign accept = (state_q == ST_IDLE) && in_valid;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_LOAD;
            ST_LOAD: begin
                state_d = ST_RUN;
                t_d     = '0;
            end
            ST_RUN: begin
                if (!hold) begin
                    if (t_q == T_LAST) state_d = ST_DONE;
                    else               t_d     = t_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    da_bit_transpose #(
        .W (DATA_WIDTH_A),
        .N (K)
    ) u_transpose (
        .words_i  (a_q),
        .slices_o (addr_d)
    );

    // Taps beyond K-1 read as zero; one extra bit keeps sums and differences exact.
    always_comb begin
        b_ext = '0;
        for (int i = 0; i < NB; i++) begin
            b_ext[i] = {b_q[i][DATA_WIDTH_B-1], b_q[i]};
        end
        ba_d    = '0;
        bm_d    = '0;
        ba_d[0] = b_ext[0];
        for (int k = 1; k < sK; k++) begin
            ba_d[k] = b_ext[2*k-1] + b_ext[2*k];
            bm_d[k] = b_ext[2*k-1] - b_ext[2*k];
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand and array registers are cleared too, so arrays read zero right after reset.
            state_q <= ST_IDLE;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            ba_q    <= '0;
            bm_q    <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            if (accept) begin
                a_q <= A;
                b_q <= B;
            end
            if (state_q == ST_LOAD) begin
                addr_q <= addr_d;
                ba_q   <= ba_d;
                bm_q   <= bm_d;
            end
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign gen_done   = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign t          = t_q;
    assign A0         = A0_MARK;
    assign addr_array = addr_q;
    assign B_A_array  = ba_q;
    assign B_M_array  = bm_q;

endmodule

// File: tb/tb_da_operand_gen.sv
// Self-checking bench for da_operand_gen: a transaction-level model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_da_operand_gen;

    localparam int W  = 16;
    localparam int WB = 16;
    localparam int KK = 9;
    localparam int SK = 5;

    typedef logic [KK-1:0][W-1:0]  a_vec_t;
    typedef logic [KK-1:0][WB-1:0] b_vec_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        in_valid;
    logic                        in_ready;
    a_vec_t                      A;
    b_vec_t                      B;
    logic                        hold;
    logic [W-1:0][KK-1:0]        addr_array;
    logic signed [SK-1:0][WB:0]  B_A_array;
    logic signed [SK-1:0][WB:0]  B_M_array;
    logic [7:0]                  t;
    logic [W-1:0]                A0;
    logic                        gen_done;
    logic                        done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    da_operand_gen #(
        .DATA_WIDTH_A (W),
        .DATA_WIDTH_B (WB),
        .K            (KK),
        .sK           (SK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .hold       (hold),
        .addr_array (addr_array),
        .B_A_array  (B_A_array),
        .B_M_array  (B_M_array),
        .t          (t),
        .A0         (A0),
        .gen_done   (gen_done),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Transaction-level model: an accepted operation spends one cycle loading,
    // then emits W slices (held slices repeat), then one done cycle.
    bit     m_active = 1'b0;
    int     m_age    = 0;
    int     m_slice  = 0;
    bit     m_t_zero = 1'b1;
    a_vec_t m_a;
    b_vec_t m_b;
    int     m_addr[W];
    int     m_ba[SK];
    int     m_bm[SK];

    function automatic int b_at(input b_vec_t b, input int i);
        if (i >= KK) return 0;
        return int'($signed(b[i]));
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < W; s++) m_addr[s] = 0;
        for (int k = 0; k < SK; k++) begin
            m_ba[k] = 0;
            m_bm[k] = 0;
        end
    endfunction

    function automatic void model_load();
        for (int s = 0; s < W; s++) begin
            m_addr[s] = 0;
            for (int j = 0; j < KK; j++)
                if (m_a[j][s]) m_addr[s] += (1 << j);
        end
        m_ba[0] = b_at(m_b, 0);
        m_bm[0] = 0;
        for (int k = 1; k < SK; k++) begin
            m_ba[k] = b_at(m_b, 2*k-1) + b_at(m_b, 2*k);
            m_bm[k] = b_at(m_b, 2*k-1) - b_at(m_b, 2*k);
        end
    endfunction

    initial begin
        bit exp_gd;
        model_clear();
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                exp_gd = m_active && (m_age >= 2) && (m_slice < W);
                check("in_ready", in_ready, !m_active);
                check("gen_done", gen_done, exp_gd);
                check("done", done, m_active && (m_slice == W));
                if (exp_gd)        check("t", t, m_slice);
                else if (m_t_zero) check("t_after_rst", t, 0);
                check("A0", A0, 1 << (W - 1));
                for (int s = 0; s < W; s++)
                    check($sformatf("addr[%0d]", s), addr_array[s], m_addr[s]);
                for (int k = 0; k < SK; k++) begin
                    check($sformatf("B_A[%0d]", k), $signed(B_A_array[k]), m_ba[k]);
                    check($sformatf("B_M[%0d]", k), $signed(B_M_array[k]), m_bm[k]);
                end
            end
            if (rst) begin
                m_active = 1'b0;
                m_age    = 0;
                m_slice  = 0;
                m_t_zero = 1'b1;
                model_clear();
            end else if (!m_active) begin
                if (in_valid) begin
                    m_a      = A;
                    m_b      = B;
                    m_active = 1'b1;
                    m_age    = 1;
                    m_slice  = 0;
                end
            end else if (m_age == 1) begin
                model_load();
                m_age    = 2;
                m_t_zero = 1'b0;
            end else if (m_slice == W) begin
                m_active = 1'b0;
            end else begin
                if (!hold) m_slice++;
                m_age++;
            end
        end
    end

    // Starts #1 after a rising edge with the DUT idle; returns #1 after the edge that
    // ends the operation. rel counts cycles from the accept edge (LOAD cycle is rel 1).
    task automatic run_op(input a_vec_t a, input b_vec_t b, input int hold_rel,
                          input int hold_len, input int pulse_rel, input int rst_rel,
                          output int gd_cnt, output int done_rel);
        int acc;
        int rel;
        bit finished;
        gd_cnt   = 0;
        done_rel = -1;
        finished = 1'b0;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        acc      = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int j = 0; j < KK; j++) begin
            A[j] = 16'($urandom);
            B[j] = 16'($urandom);
        end
        for (int i = 0; i < 60; i++) begin
            rel      = cyc - acc;
            hold     = (hold_len > 0) && (rel >= hold_rel) && (rel < hold_rel + hold_len);
            in_valid = (rel == pulse_rel);
            rst      = (rel == rst_rel);
            @(negedge clk);
            if (gen_done) gd_cnt++;
            if (done && done_rel < 0) done_rel = rel;
            @(posedge clk);
            #1;
            if (done_rel >= 0 || (rst_rel >= 0 && rel == rst_rel)) begin
                finished = 1'b1;
                break;
            end
        end
        hold     = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b0;
        check("op_terminates", finished, 1);
    endtask

    initial begin
        a_vec_t a;
        b_vec_t b;
        b_vec_t b1;
        int     gd;
        int     dr;

        rst      = 1'b1;
        in_valid = 1'b0;
        hold     = 1'b0;
        A        = '0;
        B        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_gen_done", gen_done, 0);
        check("rst_done", done, 0);
        check("rst_t", t, 0);
        check("rst_addr0", addr_array[0], 0);

        // All activations 1, weights 1..9.
        for (int j = 0; j < KK; j++) begin
            a[j]  = 16'h0001;
            b1[j] = 16'(j + 1);
        end
        run_op(a, b1, -1, 0, -1, -1, gd, dr);
        check("basic_gen_done_cycles", gd, 16);
        check("basic_done_cycle", dr, 18);
        check("basic_addr0", addr_array[0], 9'h1FF);
        for (int s = 1; s < W; s++) check($sformatf("basic_addr%0d", s), addr_array[s], 0);
        check("basic_BA0", $signed(B_A_array[0]), 1);
        check("basic_BM0", $signed(B_M_array[0]), 0);
        check("basic_BA1", $signed(B_A_array[1]), 5);
        check("basic_BM1", $signed(B_M_array[1]), -1);
        check("basic_BA4", $signed(B_A_array[4]), 17);
        check("basic_BM4", $signed(B_M_array[4]), -1);
        check("basic_A0", A0, 16'h8000);

        // Extreme weights: no wrap in the 17-bit pair results.
        b    = '0;
        b[1] = 16'h7FFF;
        b[2] = 16'h7FFF;
        run_op(a, b, -1, 0, -1, -1, gd, dr);
        check("max_BA1", $signed(B_A_array[1]), 65534);
        check("max_BM1", $signed(B_M_array[1]), 0);
        b[1] = 16'h8000;
        run_op(a, b, -1, 0, -1, -1, gd, dr);
        check("min_BM1", $signed(B_M_array[1]), -65535);
        check("min_BA1", $signed(B_A_array[1]), -1);

        // Hold for three cycles while t is 5.
        for (int j = 0; j < KK; j++) begin
            a[j] = 16'($urandom);
            b[j] = 16'($urandom);
        end
        run_op(a, b, 7, 3, -1, -1, gd, dr);
        check("hold_gen_done_cycles", gd, 19);
        check("hold_done_cycle", dr, 21);

        // in_valid mid-run is ignored; reset at t=7 aborts.
        run_op(a, b1, -1, 0, 5, 9, gd, dr);
        check("abort_gen_done_cycles", gd, 8);
        check("abort_no_done", dr, -1);
        check("abort_t", t, 0);
        check("abort_gen_done", gen_done, 0);
        check("abort_in_ready", in_ready, 1);
        for (int s = 0; s < W; s++) check($sformatf("abort_addr%0d", s), addr_array[s], 0);
        for (int k = 0; k < SK; k++) begin
            check($sformatf("abort_BA%0d", k), $signed(B_A_array[k]), 0);
            check($sformatf("abort_BM%0d", k), $signed(B_M_array[k]), 0);
        end

        // Single sign bit on tap 3.
        a    = '0;
        a[3] = 16'h8000;
        run_op(a, b1, -1, 0, -1, -1, gd, dr);
        check("sign_addr15", addr_array[15], 9'h008);
        for (int s = 0; s < W - 1; s++) check($sformatf("sign_addr%0d", s), addr_array[s], 0);
        check("sign_A0", A0, 16'h8000);

        // Randomized traffic, including corner weights and occasional reset.
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            hold     = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            for (int j = 0; j < KK; j++) begin
                A[j] = 16'($urandom);
                case ($urandom_range(0, 5))
                    0:       B[j] = 16'h8000;
                    1:       B[j] = 16'h7FFF;
                    default: B[j] = 16'($urandom);
                endcase
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        hold     = 1'b0;
        rst      = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/da_operand_gen.md
DA_OPERAND_GEN -- requirements
Module: da_operand_gen

Interface
REQ-001 SHALL have parameters: DATA_WIDTH_A, default 16, activation width; DATA_WIDTH_B, default 16, weight width; K, default 9, taps per dot product; sK, default (K+1)/2, pair-slot count.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: in_valid  in  1  A/B operand set offered.
REQ-005 SHALL have ports: in_ready  out  1  block can accept an operand set.
REQ-006 SHALL have ports: A  in  K x DATA_WIDTH_A  unsigned activations.
REQ-007 SHALL have ports: B  in  K x DATA_WIDTH_B  signed weights.
REQ-008 SHALL have ports: hold  in  1  freeze slice stepping.
REQ-009 SHALL have ports: addr_array  out  DATA_WIDTH_A x K  bit-sliced addresses.
REQ-010 SHALL have ports: B_A_array  out  sK x (DATA_WIDTH_B+1) signed  pair sums.
REQ-011 SHALL have ports: B_M_array  out  sK x (DATA_WIDTH_B+1) signed  pair differences.
REQ-012 SHALL have ports: t  out  8  current slice index.
REQ-013 SHALL have ports: A0  out  DATA_WIDTH_A  sign-slice marker.
REQ-014 SHALL have ports: gen_done  out  1  slice outputs valid for LUT.
REQ-015 SHALL have ports: done  out  1  one-cycle end-of-operation pulse.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, DONE; IDLE->LOAD on in_valid&&in_ready; LOAD->RUN unconditionally; RUN->DONE when t==DATA_WIDTH_A-1 and hold==0; DONE->IDLE unconditionally.
REQ-017 SHALL drive in_ready=1 only in IDLE; in_valid outside IDLE is ignored and does not queue.
REQ-018 SHALL capture A and B on the accepting edge; later input changes do not affect the running operation.
REQ-019 SHALL register in LOAD: addr_array[s] bit j = bit s of captured A[j], for all s, j.
REQ-020 SHALL register in LOAD: B_A_array[0]=B[0], B_M_array[0]=0; for k>=1, B_A_array[k]=B[2k-1]+B[2k], B_M_array[k]=B[2k-1]-B[2k], sign-extended to DATA_WIDTH_B+1 with no wrap.
REQ-021 SHALL treat out-of-range B indices (2k>K-1) as 0.
REQ-022 SHALL set t=0 on RUN entry, increment t by 1 per cycle in RUN with hold==0, and stop at DATA_WIDTH_A-1 (LSB-first order).
REQ-023 SHALL freeze t and state while hold==1 in RUN, with gen_done kept at 1.
REQ-024 SHALL drive gen_done=1 exactly in RUN: DATA_WIDTH_A cycles plus hold cycles.
REQ-025 SHALL pulse done for one cycle, in DONE, the cycle after the last slice.
REQ-026 SHALL make A0 constant with only bit DATA_WIDTH_A-1 set, marking the sign slice for the accumulator.
REQ-027 SHALL hold addr_array, B_A_array and B_M_array stable from LOAD until the next LOAD.
REQ-028 SHALL give latency: accept edge at cycle 0, t=0 with gen_done at cycle 2, done at cycle DATA_WIDTH_A+2 without hold; next accept no earlier than cycle DATA_WIDTH_A+3.

Reset
REQ-029 SHALL on rst return to IDLE with t=0, gen_done=0, done=0, in_ready=1 and all arrays 0, including mid-RUN.
REQ-030 SHALL give rst priority over in_valid and hold on the same edge.

Structure
REQ-031 SHALL place the default widths, K, the sK derivation and the FSM state enum in shared package da_pkg.
REQ-032 SHALL use one sub-module, da_bit_transpose, for the combinational A-to-bit-slice transpose; the pair adders stay inline.

Verification
REQ-033 SHALL cover: all A=16'h0001 and B[j]=j+1 -> addr_array[0]=9'h1FF, addr_array[1..15]=0, B_A[0]=1, B_M[0]=0, B_A[1]=5, B_M[1]=-1, B_A[4]=17, B_M[4]=-1; gen_done for 16 cycles; done at cycle 18.
REQ-034 SHALL cover: B[1]=B[2]=32767 -> B_A[1]=65534; B[1]=-32768, B[2]=32767 -> B_M[1]=-65535 (17-bit, no wrap).
REQ-035 SHALL cover: hold=1 for 3 cycles at t=5 -> t stays 5, gen_done stays 1, done moves to cycle 21.
REQ-036 SHALL cover: in_valid pulsed at t=3 -> in_ready=0 and outputs unchanged; rst at t=7 -> next cycle t=0, gen_done=0, in_ready=1, arrays 0.
REQ-037 SHALL cover: A[3]=16'h8000, others 0 -> addr_array[15]=9'h008, all other slices 0, A0=16'h8000.
